// File: rtl/inst_line_queue.sv
// inst_line_queue: buffers 64B Icache lines for Fetch0 PCs and hands them to
// decode one 32-bit instruction per cycle. Each queue entry is one line; the
// head entry is walked slot by slot until slot 15 retires it.
// Optional feature: define IQ_PERF_CNT_EN to add stall_cnt_o, a saturating
// count of cycles with stall_o asserted.
module inst_line_queue #(
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redir_i,
  input  logic         line_valid_i,
  input  logic [63:0]  line_pc_i,
  input  logic [511:0] line_data_i,
  output logic         stall_o,
  output logic         inst_valid_o,
  output logic [31:0]  inst_o,
  output logic [63:0]  inst_pc_o,
  input  logic         inst_ready_i,
  output logic         ovf_o
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]  stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE     = (PW+1)'(1);
  localparam logic [PW:0]   STALL_LEVEL = (PW+1)'(DEPTH - SKID);
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);

  // Line storage: PC bits above the line offset, starting slot, and data.
  logic [57:0]  entry_pc   [DEPTH];
  logic [3:0]   entry_slot [DEPTH];
  logic [511:0] entry_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    head_slot;

  logic [PW-1:0] next_rd;
  logic [PW:0]   count_nxt;
  logic [3:0]    head_slot_nxt;
  logic [511:0]  head_data;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;
  logic          retire;

  // The two byte-offset bits of the line PC carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^line_pc_i[1:0];

  // Fullness is judged on the registered count, so a pop never makes room
  // for a push in the same cycle; a redirect suppresses both directions.
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push    = line_valid_i & ~redir_i & ~full;
  assign drop    = line_valid_i & ~redir_i & full;
  assign pop     = inst_valid_o & inst_ready_i & ~redir_i;
  assign retire  = pop & (head_slot == 4'hF);
  assign next_rd = rd_ptr + PTR_ONE;

  // Decode-facing view of the head entry; zero whenever the queue is empty.
  assign head_data    = entry_data[rd_ptr];
  assign inst_valid_o = ~empty;
  assign inst_o       = inst_valid_o ? head_data[{head_slot, 5'd0} +: 32] : 32'd0;
  assign inst_pc_o    = inst_valid_o ? {entry_pc[rd_ptr], head_slot, 2'b00} : 64'd0;

  // Stall early enough that every line already in flight still finds room.
  assign stall_o = (count >= STALL_LEVEL);

  // Occupancy only moves on line-level events: a push or a retiring pop.
  always_comb begin
    count_nxt = count;
    case ({push, retire})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Pick the slot the head will present next: advance within the line, or on
  // retirement jump to the start slot of the following line, which may be the
  // line arriving this very cycle when the queue holds only the retiring one.
  always_comb begin
    head_slot_nxt = head_slot;
    if (retire) begin
      if (count > CNT_ONE) begin
        head_slot_nxt = entry_slot[next_rd];
      end else if (push) begin
        head_slot_nxt = line_pc_i[5:2];
      end else begin
        head_slot_nxt = 4'd0;
      end
    end else if (pop) begin
      head_slot_nxt = head_slot + 4'd1;
    end else if (push && empty) begin
      head_slot_nxt = line_pc_i[5:2];
    end
  end

  // Control state: reset clears all, a redirect empties the queue but keeps
  // the sticky overflow flag, otherwise apply push/pop/retire updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_slot <= 4'd0;
      ovf_o     <= 1'b0;
    end else if (redir_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_slot <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (retire) begin
        rd_ptr <= next_rd;
      end
      if (drop) begin
        ovf_o <= 1'b1;
      end
      count     <= count_nxt;
      head_slot <= head_slot_nxt;
    end
  end

  // Line storage write; contents need no reset because count gates the output.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      entry_pc[wr_ptr]   <= line_pc_i[63:6];
      entry_slot[wr_ptr] <= line_pc_i[5:2];
      entry_data[wr_ptr] <= line_data_i;
    end
  end

`ifdef IQ_PERF_CNT_EN
  // Saturating count of stalled cycles; survives redirects, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o <= 32'd0;
    end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
